sseg_serial_driver: RTL and testbench



---
 rtl/sseg_pkg.sv | 45 ++++
 rtl/hex_to_seg.sv | 25 ++
 rtl/sseg_serial_driver.sv | 118 +++++++++++
 tb/tb_sseg_serial_driver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// ============================================================================
// sseg_pkg : shared types and constants for the serial seven-segment driver
// Rev 1.0
// ============================================================================
`default_nettype none

package sseg_pkg;

  localparam logic [7:0]  SEG_BLANK      = 8'hFF;
  localparam int unsigned DIGITS_DEFAULT = 8;
  localparam int unsigned FRAME_BITS     = 8 * DIGITS_DEFAULT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  // Active-low pattern {dp,g,f,e,d,c,b,a}; dp is always returned off here.
  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex_to_seg.sv
// ============================================================================
// hex_to_seg : one digit, 4-bit value + decimal point + blank -> segment byte
// Rev 1.0
// ============================================================================
`default_nettype none

module hex_to_seg
  import sseg_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       point_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  logic [7:0] w_pattern;

  always_comb begin
    w_pattern = hex_seg(value_i);
    seg_o     = blank_i ? SEG_BLANK : {~point_i, w_pattern[6:0]};
  end

endmodule

`default_nettype wire

// File: rtl/sseg_serial_driver.sv
// ============================================================================
// sseg_serial_driver : decodes hex digits and shifts one frame MSB-first into
//                      an external shift-register chain per refresh edge.
// Rev 1.0
// ============================================================================
`default_nettype none

module sseg_serial_driver
  import sseg_pkg::*;
#(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned HALF_PERIOD = 2
)(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  flash,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     les,
  output logic                  seg_clk,
  output logic                  seg_clrn,
  output logic                  seg_sout,
  output logic                  seg_pen
);

  localparam int unsigned c_frame_bits = 8 * DIGITS;
  localparam int unsigned c_cnt_w      = $clog2(c_frame_bits);
  localparam logic [8:0]  c_ph_rise    = 9'(HALF_PERIOD - 1);
  localparam logic [8:0]  c_ph_last    = 9'(2 * HALF_PERIOD - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_frame_bits - 1);

  state_e                    state_q;
  logic                      start_q;
  logic [c_frame_bits-1:0]   frame_q;
  logic [c_cnt_w-1:0]        cnt_q;
  logic [8:0]                ph_q;
  logic                      seg_clk_q;
  logic                      seg_clrn_q;
  logic                      seg_sout_q;
  logic                      seg_pen_q;

  logic                      w_trigger;
  logic [c_frame_bits-1:0]   w_frame;

  assign w_trigger = start & ~start_q;

  // Digit 0 lands in the low byte, so the highest digit is shifted out first.
  generate
    for (genvar gi = 0; gi < int'(DIGITS); gi++) begin : g_digits
      hex_to_seg u_hex_to_seg (
        .value_i (hexs[4*gi +: 4]),
        .point_i (point[gi]),
        .blank_i (flash & les[gi]),
        .seg_o   (w_frame[8*gi +: 8])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      frame_q    <= '0;
      cnt_q      <= '0;
      ph_q       <= '0;
      seg_clk_q  <= 1'b0;
      seg_clrn_q <= 1'b0;
      seg_sout_q <= 1'b1;
      seg_pen_q  <= 1'b0;
    end else begin
      start_q    <= start;
      seg_clrn_q <= 1'b1;
      case (state_q)
        IDLE: begin
          seg_clk_q <= 1'b0;
          if (w_trigger) state_q <= LOAD;
        end
        LOAD: begin
          frame_q    <= w_frame;
          seg_sout_q <= w_frame[c_frame_bits-1];
          seg_clk_q  <= 1'b0;
          seg_pen_q  <= 1'b0;
          cnt_q      <= '0;
          ph_q       <= '0;
          state_q    <= SHIFT;
        end
        SHIFT: begin
          // Data changes only on the falling edge, so it is stable while high.
          if (ph_q == c_ph_last) begin
            ph_q      <= '0;
            seg_clk_q <= 1'b0;
            if (cnt_q == c_cnt_last) begin
              seg_pen_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              frame_q    <= {frame_q[c_frame_bits-2:0], 1'b0};
              seg_sout_q <= frame_q[c_frame_bits-2];
            end
          end else begin
            if (ph_q == c_ph_rise) seg_clk_q <= 1'b1;
            ph_q <= ph_q + 9'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign seg_clk  = seg_clk_q;
  assign seg_clrn = seg_clrn_q;
  assign seg_sout = seg_sout_q;
  assign seg_pen  = seg_pen_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_serial_driver.sv
// ============================================================================
// tb_sseg_serial_driver : self-checking bench with a cycle-count output model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sseg_serial_driver;

  localparam int HP    = 2;
  localparam int NB    = 64;
  localparam int FRAME = 1 + NB * 2 * HP;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic        flash = 1'b0;
  logic [31:0] hexs = '0;
  logic [7:0]  point = '0;
  logic [7:0]  les = '0;
  logic        seg_clk, seg_clrn, seg_sout, seg_pen;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sseg_serial_driver #(.DIGITS(8), .HALF_PERIOD(HP)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .flash    (flash),
    .hexs     (hexs),
    .point    (point),
    .les      (les),
    .seg_clk  (seg_clk),
    .seg_clrn (seg_clrn),
    .seg_sout (seg_sout),
    .seg_pen  (seg_pen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [63:0] model_frame(input logic [31:0] h, input logic [7:0] p,
                                              input logic [7:0] l, input logic f);
    logic [63:0] fr;
    logic [7:0]  b;
    for (int d = 0; d < 8; d++) begin
      b = tbl[h[4*d +: 4]];
      b[7] = ~p[d];
      if (f && l[d]) b = 8'hFF;
      fr[8*d +: 8] = b;
    end
    return fr;
  endfunction

  // Output model: outputs as a function of cycles elapsed since the trigger edge.
  bit          m_busy, m_sprev, m_clk, m_clrn, m_sout, m_pen;
  int          m_k;
  logic [63:0] m_frame;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 0; m_sprev = 0; m_clk = 0; m_clrn = 0; m_sout = 1; m_pen = 0; m_k = 0;
    end else begin
      m_clrn = 1;
      if (m_busy) begin
        m_k++;
        if (m_k == 1) begin
          m_frame = model_frame(hexs, point, les, flash);
          m_pen   = 0;
        end
        if (m_k < FRAME) begin
          m_clk  = (((m_k - 1) % (2 * HP)) >= HP);
          m_sout = m_frame[63 - (m_k - 1) / (2 * HP)];
        end else begin
          m_clk  = 0;
          m_pen  = 1;
          m_busy = 0;
        end
      end else if (start && !m_sprev) begin
        m_busy = 1;
        m_k    = 0;
      end
      m_sprev = start;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({seg_clk, seg_clrn, seg_sout, seg_pen} !== {m_clk, m_clrn, m_sout, m_pen}) begin
      errors++;
      $display("FAIL outputs @cyc %0d: clk/clrn/sout/pen got %b%b%b%b want %b%b%b%b", cyc,
               seg_clk, seg_clrn, seg_sout, seg_pen, m_clk, m_clrn, m_sout, m_pen);
    end
  end

  logic [63:0] cap = '0;
  int          capn = 0;
  always @(posedge seg_clk) begin
    cap = {cap[62:0], seg_sout};
    capn++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Pulse start once and wait for the frame; optionally disturb it mid-flight.
  task automatic do_frame(input string name, input logic [31:0] h, input logic [7:0] p,
                          input logic [7:0] l, input logic f, input bit use_lit,
                          input logic [63:0] lit, input bit disturb);
    int  t;
    bit  done;
    @(negedge clk);
    hexs = h; point = p; les = l; flash = f;
    start = 1'b1; capn = 0; t = cyc + 1; done = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cyc > t && seg_pen) begin done = 1; break; end
      if (disturb && i == 40) begin start = 1'b1; hexs = $urandom; point = $urandom; end
      if (disturb && i == 41) start = 1'b0;
    end
    chk({name, " done"}, 64'(done), 64'd1);
    chk({name, " latency"}, 64'(cyc - t), 64'(FRAME));
    chk({name, " bits"}, 64'(capn), 64'd64);
    chk({name, " model"}, cap, m_frame);
    if (use_lit) chk({name, " frame"}, cap, lit);
    if (disturb) begin
      repeat (300) @(negedge clk);
      chk({name, " no refire"}, 64'(capn), 64'd64);
    end
  endtask

  initial begin
    #1 rstn = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset outputs", {60'd0, seg_clk, seg_clrn, seg_sout, seg_pen}, 64'b0010);
    rstn = 1'b1;
    @(negedge clk);
    chk("clrn after release", 64'(seg_clrn), 64'd1);
    capn = 0;
    repeat (20) @(negedge clk);
    chk("idle no seg_clk", 64'(capn), 64'd0);

    do_frame("t2", 32'h0400_0003, 8'h41, 8'h00, 1'b1, 1, 64'hC019C0C0C0C0C030, 0);
    do_frame("t3", 32'h89AB_CDEF, 8'h00, 8'h00, 1'b0, 1, 64'h80908883C6A1868E, 0);
    do_frame("t4a", 32'h0000_0005, 8'h00, 8'h01, 1'b1, 1, 64'hC0C0C0C0C0C0C0FF, 0);
    do_frame("t4b", 32'h0000_0005, 8'h00, 8'h01, 1'b0, 1, 64'hC0C0C0C0C0C0C092, 0);

    // Start held high for a long time, with inputs changing mid-frame.
    @(negedge clk);
    hexs = 32'h1234_5678; point = 8'h80; les = 8'h00; flash = 1'b0;
    start = 1'b1; capn = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 50) hexs = 32'hFFFF_0000;
    end
    chk("held start bits", 64'(capn), 64'd64);
    chk("held start frame", cap, 64'h79A4B0999282F880);
    start = 1'b0;

    do_frame("t5 retrigger", 32'h89AB_CDEF, 8'h00, 8'h00, 1'b0, 1, 64'h80908883C6A1868E, 1);

    // Asynchronous reset in the middle of bit 20.
    @(negedge clk);
    hexs = 32'hDEAD_BEEF; start = 1'b1; capn = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && capn < 20; i++) @(negedge clk);
    chk("reached bit 20", 64'(capn), 64'd20);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk("abort outputs", {60'd0, seg_clk, seg_clrn, seg_sout, seg_pen}, 64'b0010);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    do_frame("after abort", 32'h89AB_CDEF, 8'h00, 8'h00, 1'b0, 1, 64'h80908883C6A1868E, 0);

    for (int n = 0; n < 8; n++)
      do_frame("random", $urandom, 8'($urandom), 8'($urandom), 1'($urandom), 0, '0,
               bit'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
